// File: rtl/coincidence_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : coincidence_detector
// Purpose  : Pulses when synchronized rising edges on button_A and button_B
//            fall within TOLERANCE_CYCLES of each other.
//            Optional macro COINCIDENCE_COUNT_EN adds a saturating 16-bit
//            coincidence_count output.
// Revision : 1.0
// ============================================================================
module coincidence_detector #(
    parameter int TOLERANCE_CYCLES = 5000,
    parameter int PULSE_CYCLES     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        button_A,
    input  logic        button_B,
    output logic        coincidence_detected
`ifdef COINCIDENCE_COUNT_EN
    ,
    output logic [15:0] coincidence_count
`endif
);

    localparam int                 c_CNT_W = $clog2(TOLERANCE_CYCLES + 2);
    localparam logic [c_CNT_W-1:0] c_TOL   = c_CNT_W'(TOLERANCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
    localparam logic [7:0]         c_PLS   = 8'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        WAIT_A = 2'd2,
        PULSE  = 2'd3
    } state_t;

    logic [1:0]         r_rdy;
    logic               r_a_meta, r_a_sync, r_a_prev, r_a_evt;
    logic               r_b_meta, r_b_sync, r_b_prev, r_b_evt;
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_pcnt;
    logic               w_opp;
    logic               w_start;

    // Until the synchronizers hold real input samples, the previous level is
    // treated as high so an input already high at reset release is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy    <= 2'b00;
            r_a_meta <= 1'b0;
            r_a_sync <= 1'b0;
            r_a_prev <= 1'b0;
            r_a_evt  <= 1'b0;
            r_b_meta <= 1'b0;
            r_b_sync <= 1'b0;
            r_b_prev <= 1'b0;
            r_b_evt  <= 1'b0;
        end else begin
            r_rdy    <= {r_rdy[0], 1'b1};
            r_a_meta <= button_A;
            r_a_sync <= r_a_meta;
            r_a_prev <= r_rdy[1] ? r_a_sync : 1'b1;
            r_a_evt  <= r_a_sync & ~r_a_prev;
            r_b_meta <= button_B;
            r_b_sync <= r_b_meta;
            r_b_prev <= r_rdy[1] ? r_b_sync : 1'b1;
            r_b_evt  <= r_b_sync & ~r_b_prev;
        end
    end

    // r_cnt holds separation-1 at the moment the opposite event is evaluated.
    assign w_opp   = (r_state == WAIT_B) ? r_b_evt : r_a_evt;
    assign w_start = ((r_state != PULSE) && r_a_evt && r_b_evt) ||
                     (((r_state == WAIT_A) || (r_state == WAIT_B)) &&
                      w_opp && (r_cnt < c_TOL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state              <= IDLE;
            r_cnt                <= '0;
            r_pcnt               <= '0;
            coincidence_detected <= 1'b0;
        end else if (w_start) begin
            r_state              <= PULSE;
            r_cnt                <= '0;
            r_pcnt               <= c_PLS;
            coincidence_detected <= 1'b1;
        end else begin
            case (r_state)
                IDLE, WAIT_A, WAIT_B: begin
                    if (r_a_evt) begin
                        r_state <= WAIT_B;
                        r_cnt   <= '0;
                    end else if (r_b_evt) begin
                        r_state <= WAIT_A;
                        r_cnt   <= '0;
                    end else if (r_state == IDLE) begin
                        r_cnt   <= '0;
                    end else if (r_cnt >= c_TOL) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + c_ONE;
                    end
                end
                PULSE: begin
                    if (r_pcnt == 8'd0) begin
                        r_state              <= IDLE;
                        coincidence_detected <= 1'b0;
                    end else begin
                        r_pcnt <= r_pcnt - 8'd1;
                    end
                end
                default: begin
                    r_state              <= IDLE;
                    coincidence_detected <= 1'b0;
                end
            endcase
        end
    end

`ifdef COINCIDENCE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coincidence_count <= 16'd0;
        end else if (w_start && (coincidence_count != 16'hFFFF)) begin
            coincidence_count <= coincidence_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_coincidence_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_coincidence_detector
// Purpose  : Directed and random stimulus on two detector configurations,
//            checked cycle by cycle against an event-level reference model.
// Revision : 1.0
// ============================================================================
module tb_coincidence_detector;

    localparam int BIG_TOL = 5000;
    localparam int BIG_PC  = 1;
    localparam int SML_TOL = 6;
    localparam int SML_PC  = 3;
    localparam int MAXN    = 11000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_a = 1'b0;
    logic btn_b = 1'b0;
    logic out_big, out_sml;
`ifdef COINCIDENCE_COUNT_EN
    logic [15:0] cnt_big, cnt_sml;
`endif

    always #5 clk = ~clk;

    coincidence_detector #(.TOLERANCE_CYCLES(BIG_TOL), .PULSE_CYCLES(BIG_PC)) u_dut_big (
        .clk                  (clk),
        .rst_n                (rst_n),
        .button_A             (btn_a),
        .button_B             (btn_b),
        .coincidence_detected (out_big)
`ifdef COINCIDENCE_COUNT_EN
        ,
        .coincidence_count    (cnt_big)
`endif
    );

    coincidence_detector #(.TOLERANCE_CYCLES(SML_TOL), .PULSE_CYCLES(SML_PC)) u_dut_sml (
        .clk                  (clk),
        .rst_n                (rst_n),
        .button_A             (btn_a),
        .button_B             (btn_b),
        .coincidence_detected (out_sml)
`ifdef COINCIDENCE_COUNT_EN
        ,
        .coincidence_count    (cnt_sml)
`endif
    );

    bit lvl_a[MAXN];
    bit lvl_b[MAXN];
    bit exp_big[MAXN];
    bit exp_sml[MAXN];
    int n_cyc;
    int npl_big, npl_sml;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic clear_stim(input int n);
        n_cyc = n;
        for (int i = 0; i < MAXN; i++) begin
            lvl_a[i] = 1'b0;
            lvl_b[i] = 1'b0;
        end
    endtask

    task automatic set_a(input int from, input int to);
        for (int i = from; i <= to; i++) lvl_a[i] = 1'b1;
    endtask

    task automatic set_b(input int from, input int to);
        for (int i = from; i <= to; i++) lvl_b[i] = 1'b1;
    endtask

    // Sample index k is the k-th rising clk edge after reset release; a
    // coincidence decided on sample k shows at the output after edge k+3.
    task automatic build_model(input int tol, input int pc, input int sel, output int npl);
        int pend_ch;
        int pend_t;
        int busy;
        bit ea, eb, hit;
        pend_ch = -1;
        pend_t  = 0;
        busy    = -1;
        npl     = 0;
        for (int i = 0; i < n_cyc; i++) begin
            if (sel == 0) exp_big[i] = 1'b0;
            else          exp_sml[i] = 1'b0;
        end
        for (int k = 1; k < n_cyc; k++) begin
            ea = lvl_a[k] && !lvl_a[k-1];
            eb = lvl_b[k] && !lvl_b[k-1];
            if (k <= busy || !(ea || eb)) continue;
            hit = (ea && eb) ||
                  (pend_ch >= 0 && (k - pend_t) <= tol &&
                   ((pend_ch == 0 && eb) || (pend_ch == 1 && ea)));
            if (hit) begin
                npl++;
                busy    = k + pc;
                pend_ch = -1;
                for (int j = k + 3; j < k + 3 + pc && j < n_cyc; j++) begin
                    if (sel == 0) exp_big[j] = 1'b1;
                    else          exp_sml[j] = 1'b1;
                end
            end else begin
                pend_ch = ea ? 0 : 1;
                pend_t  = k;
            end
        end
    endtask

    task automatic check(input string tag, input int k, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0b expected=%0b", tag, k, obs, expv);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic run_seq(input string tag);
        build_model(BIG_TOL, BIG_PC, 0, npl_big);
        build_model(SML_TOL, SML_PC, 1, npl_sml);
        @(negedge clk);
        rst_n = 1'b0;
        btn_a = lvl_a[0];
        btn_b = lvl_b[0];
        @(negedge clk);
        check({tag, "_rst_big"}, -1, out_big, 1'b0);
        check({tag, "_rst_sml"}, -1, out_sml, 1'b0);
`ifdef COINCIDENCE_COUNT_EN
        check16({tag, "_rst_cnt_big"}, cnt_big, 16'd0);
        check16({tag, "_rst_cnt_sml"}, cnt_sml, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < n_cyc; k++) begin
            btn_a = lvl_a[k];
            btn_b = lvl_b[k];
            @(posedge clk);
            #1;
            check({tag, "_big"}, k, out_big, exp_big[k]);
            check({tag, "_sml"}, k, out_sml, exp_sml[k]);
            @(negedge clk);
        end
`ifdef COINCIDENCE_COUNT_EN
        check16({tag, "_cnt_big"}, cnt_big, 16'(npl_big));
        check16({tag, "_cnt_sml"}, cnt_sml, 16'(npl_sml));
`endif
    endtask

    initial begin
        // Same-cycle A and B
        clear_stim(14); set_a(2, 2); set_b(2, 2);
        run_seq("same_cycle");

        // A then B two cycles later, and the mirror
        clear_stim(16); set_a(2, 2); set_b(4, 4);
        run_seq("a_then_b");
        clear_stim(16); set_b(2, 2); set_a(4, 4);
        run_seq("b_then_a");

        // Far apart: no coincidence
        clear_stim(10012); set_a(2, 2); set_b(10002, 10002);
        run_seq("sep_10000");

        // Window boundary
        clear_stim(5012); set_a(2, 2); set_b(5002, 5002);
        run_seq("sep_5000");
        clear_stim(5012); set_a(2, 2); set_b(5003, 5003);
        run_seq("sep_5001");

        // Small-window boundary on the second instance
        clear_stim(24); set_b(2, 2); set_a(8, 8);
        run_seq("sml_sep_6");
        clear_stim(24); set_b(2, 2); set_a(9, 9);
        run_seq("sml_sep_7");

        // A held 20 cycles, B 3 cycles after A rises
        clear_stim(32); set_a(2, 21); set_b(5, 5);
        run_seq("a_held");

        // A already high at release must not count until it re-rises
        clear_stim(24); set_a(0, 9); set_b(5, 5); set_a(12, 13);
        run_seq("held_at_release");

        // Same-channel restart then opposite event
        clear_stim(30); set_a(2, 2); set_a(6, 6); set_b(12, 12);
        run_seq("restart");

        // Reset 100 cycles into a WAIT_B window, then B alone
        clear_stim(103); set_a(2, 2);
        run_seq("win_pre");
        rst_n = 1'b0;
        #1;
        check("win_async_big", -1, out_big, 1'b0);
        check("win_async_sml", -1, out_sml, 1'b0);
        clear_stim(20); set_b(3, 3);
        run_seq("win_post");

        // Reset mid-pulse forces output low immediately
        clear_stim(6); set_a(2, 2); set_b(2, 2);
        run_seq("pulse_pre");
        check("pulse_high_big", -1, out_big, 1'b1);
        check("pulse_high_sml", -1, out_sml, 1'b1);
        rst_n = 1'b0;
        #1;
        check("pulse_async_big", -1, out_big, 1'b0);
        check("pulse_async_sml", -1, out_sml, 1'b0);
        clear_stim(12);
        run_seq("pulse_post");

        // Random level sequences
        for (int r = 0; r < 3; r++) begin
            clear_stim(1500);
            for (int k = 1; k < n_cyc - 12; k++) begin
                lvl_a[k] = ($urandom_range(0, 9) < 2) ? !lvl_a[k-1] : lvl_a[k-1];
                lvl_b[k] = ($urandom_range(0, 9) < 2) ? !lvl_b[k-1] : lvl_b[k-1];
            end
            run_seq("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
